load_store_unit: RTL

Parametrised memory-access stage that replaces the purely combinational EX→WB pass-through with a real load/store unit. It sits between the execute and writeback stages, talks to data memory over a request/grant/response handshake with variable latency, and stalls the pipeline while an access is outstanding. It also generates byte enables and store-data lane replication, sign- and zero-extends loads, detects misaligned accesses, and aborts hung accesses with a timeout fault.

---
 rtl/load_store_unit.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage between EX and WB: drives a req/gnt/rvalid data-memory port,
// steers byte lanes, extends load data, traps misaligned accesses and hung buses.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  input  logic [4:0]        rd,
  input  logic              reg_write,
  output logic              stall,
  output logic [XLEN-1:0]   fwd_alu_result,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_result,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int BE_W   = XLEN / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_LD   = 2'b01;
  localparam logic [1:0] CAUSE_ST   = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
    logic [2:0] lane3;
    logic       mis;
    lane3 = 3'(lane);
    case (sz)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lane3[0];
      2'b10:   mis = |lane3[1:0];
      default: mis = |lane3;
    endcase
    return mis;
  endfunction

  function automatic logic [BE_W-1:0] lane_be(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
    logic [BE_W-1:0] m;
    case (sz)
      2'b00:   m = BE_W'(8'h01);
      2'b01:   m = BE_W'(8'h03);
      2'b10:   m = BE_W'(8'h0F);
      default: m = {BE_W{1'b1}};
    endcase
    return m << lane;
  endfunction

  function automatic logic [XLEN-1:0] replicate(input logic [1:0] sz, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (sz)
      2'b00:   w = {(XLEN/8){d[7:0]}};
      2'b01:   w = {(XLEN/16){d[15:0]}};
      2'b10:   w = {(XLEN/32){d[31:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                                input logic [LANE_W-1:0] lane,
                                                input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rdata >> {lane, 3'b000};
    case (sz)
      2'b00:   if (uns) res = XLEN'(sh[7:0]);  else res = XLEN'($signed(sh[7:0]));
      2'b01:   if (uns) res = XLEN'(sh[15:0]); else res = XLEN'($signed(sh[15:0]));
      2'b10:   if (uns) res = XLEN'(sh[31:0]); else res = XLEN'($signed(sh[31:0]));
      default: res = sh;
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        sz_q, sz_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d;

  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_result_q, wb_result_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_rw_q, wb_rw_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;

  logic [1:0]        sz_in_s;
  logic [LANE_W-1:0] lane_in_s;
  logic              is_mem_in_s;
  logic              mis_in_s;
  logic [BE_W-1:0]   be_in_s;
  logic [XLEN-1:0]   wdata_in_s;
  logic              timeout_s;
  logic              req_s;
  logic              stall_s;
  logic              out_we_s;
  logic [XLEN-1:0]   out_addr_s;
  logic [BE_W-1:0]   out_be_s;
  logic [XLEN-1:0]   out_wdata_s;

  // Doubleword sizes do not exist on a 32-bit datapath; treat them as word accesses.
  assign sz_in_s     = (XLEN == 32 && funct3[1:0] == 2'b11) ? 2'b10 : funct3[1:0];
  assign lane_in_s   = addr[LANE_W-1:0];
  assign is_mem_in_s = mem_read | mem_write;
  assign mis_in_s    = is_misaligned(sz_in_s, lane_in_s);
  assign be_in_s     = lane_be(sz_in_s, lane_in_s);
  assign wdata_in_s  = replicate(sz_in_s, store_data);
  assign timeout_s   = (cnt_q >= CNT_W'(TIMEOUT - 1));

  // Next-state, handshake outputs and writeback values for the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    sz_d        = sz_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    req_s       = 1'b0;
    stall_s     = 1'b0;
    out_we_s    = we_q;
    out_addr_s  = addr_q;
    out_be_s    = be_q;
    out_wdata_s = wdata_q;
    wb_valid_d  = 1'b0;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = 1'b0;
    fault_d     = 1'b0;
    cause_d     = cause_q;

    case (state_q)
      S_IDLE: begin
        cnt_d       = {CNT_W{1'b0}};
        addr_d      = addr;
        be_d        = be_in_s;
        wdata_d     = wdata_in_s;
        we_d        = mem_write;
        sz_d        = sz_in_s;
        uns_d       = funct3[2];
        rd_d        = rd;
        rw_d        = reg_write;
        out_we_s    = mem_write;
        out_addr_s  = addr;
        out_be_s    = be_in_s;
        out_wdata_s = wdata_in_s;
        if (!ex_valid) begin
          state_d = S_IDLE;
        end else if (!is_mem_in_s) begin
          wb_valid_d  = 1'b1;
          wb_result_d = addr;
          wb_rd_d     = rd;
          wb_rw_d     = reg_write;
          cause_d     = CAUSE_NONE;
        end else if (mis_in_s) begin
          wb_valid_d  = 1'b1;
          wb_result_d = addr;
          wb_rd_d     = rd;
          fault_d     = 1'b1;
          cause_d     = mem_write ? CAUSE_ST : CAUSE_LD;
        end else begin
          req_s = 1'b1;
          if (dmem_gnt && mem_write) begin
            wb_valid_d  = 1'b1;
            wb_result_d = addr;
            wb_rd_d     = rd;
            cause_d     = CAUSE_NONE;
          end else begin
            stall_s = 1'b1;
            state_d = dmem_gnt ? S_RESP : S_REQ;
          end
        end
      end
      S_REQ: begin
        req_s = 1'b1;
        if (dmem_gnt) begin
          if (we_q) begin
            state_d     = S_IDLE;
            wb_valid_d  = 1'b1;
            wb_result_d = addr_q;
            wb_rd_d     = rd_q;
            cause_d     = CAUSE_NONE;
          end else begin
            state_d = S_RESP;
            cnt_d   = cnt_q + CNT_W'(1);
            stall_s = 1'b1;
          end
        end else if (timeout_s) begin
          state_d     = S_IDLE;
          wb_valid_d  = 1'b1;
          wb_result_d = addr_q;
          wb_rd_d     = rd_q;
          fault_d     = 1'b1;
          cause_d     = CAUSE_TMO;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          stall_s = 1'b1;
        end
      end
      S_RESP: begin
        if (dmem_rvalid) begin
          state_d     = S_IDLE;
          wb_valid_d  = 1'b1;
          wb_result_d = load_ext(dmem_rdata, addr_q[LANE_W-1:0], sz_q, uns_q);
          wb_rd_d     = rd_q;
          wb_rw_d     = rw_q;
          cause_d     = CAUSE_NONE;
        end else if (timeout_s) begin
          state_d     = S_IDLE;
          wb_valid_d  = 1'b1;
          wb_result_d = addr_q;
          wb_rd_d     = rd_q;
          fault_d     = 1'b1;
          cause_d     = CAUSE_TMO;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched access and registered writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      addr_q      <= {XLEN{1'b0}};
      be_q        <= {BE_W{1'b0}};
      wdata_q     <= {XLEN{1'b0}};
      we_q        <= 1'b0;
      sz_q        <= 2'b00;
      uns_q       <= 1'b0;
      rd_q        <= 5'd0;
      rw_q        <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= {XLEN{1'b0}};
      wb_rd_q     <= 5'd0;
      wb_rw_q     <= 1'b0;
      fault_q     <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      sz_q        <= sz_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
    end
  end

  assign stall          = stall_s;
  assign fwd_alu_result = addr;
  assign dmem_req       = req_s;
  assign dmem_we        = req_s & out_we_s;
  assign dmem_addr      = req_s ? (out_addr_s[ADDR_W-1:0] & ~ADDR_W'(BE_W - 1)) : {ADDR_W{1'b0}};
  assign dmem_be        = req_s ? out_be_s : {BE_W{1'b0}};
  assign dmem_wdata     = req_s ? out_wdata_s : {XLEN{1'b0}};
  assign wb_valid       = wb_valid_q;
  assign wb_result      = wb_result_q;
  assign wb_rd          = wb_rd_q;
  assign wb_reg_write   = wb_rw_q;
  assign fault          = fault_q;
  assign fault_cause    = cause_q;

endmodule
